// File: rtl/bcd_subtractor_seq.sv
// ---------------------------------------------------------------------------
// bcd_subtractor_seq
//
// Digit-serial packed-BCD subtractor: diff = a - b - bin over NDIGITS decimal
// digits, one digit per clock, least significant digit first. It trades the
// parallel digit chain of a combinational BCD subtractor for one small digit
// slice reused over several cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (released synchronously upstream)
//   a          minuend, packed BCD, digit 0 in bits [3:0]
//   b          subtrahend, packed BCD
//   bin        borrow in
//   in_valid   operands valid
//   in_ready   block can accept operands (high only while idle)
//   diff       packed BCD result, ten's complement when a borrow leaves the top
//   bout       borrow out: 1 when a < b + bin
//   err        some digit of a or b was greater than 9 in this transaction
//   out_valid  diff/bout/err valid
//   out_ready  consumer accepts the result
// ---------------------------------------------------------------------------
module bcd_subtractor_seq #(
    parameter int NDIGITS = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    input  logic                   bin,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [4*NDIGITS-1:0]   diff,
    output logic                   bout,
    output logic                   err,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int W     = 4 * NDIGITS;
    localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NDIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;

    // Operand copies taken at acceptance so later input changes are harmless
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       a_d;
    logic [W-1:0]       b_d;

    logic               borrow_q;
    logic               borrow_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;

    logic [W-1:0]       diff_d;
    logic               bout_d;
    logic               err_d;
    logic               out_valid_d;

    // Digit slice signals for the digit currently being processed
    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic [5:0]         raw;
    logic [5:0]         raw_adj;
    logic               raw_neg;
    logic [3:0]         digit;
    logic               digit_bad;

    assign in_ready = (state == IDLE);

    // One digit of subtraction. The 6-bit result spans -16..15, so bit 5 is
    // the sign; a negative result borrows from the next digit and is
    // corrected by adding ten. Non-decimal digits follow the same rule.
    always_comb begin
        a_dig     = a_q[4*idx_q +: 4];
        b_dig     = b_q[4*idx_q +: 4];
        raw       = {2'b00, a_dig} - {2'b00, b_dig} - {5'b00000, borrow_q};
        raw_neg   = raw[5];
        raw_adj   = raw + 6'd10;
        digit     = raw_neg ? raw_adj[3:0] : raw[3:0];
        digit_bad = (a_dig > 4'd9) || (b_dig > 4'd9);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_next  = state;
        a_d         = a_q;
        b_d         = b_q;
        borrow_d    = borrow_q;
        idx_d       = idx_q;
        diff_d      = diff;
        bout_d      = bout;
        err_d       = err;
        out_valid_d = out_valid;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    borrow_d   = bin;
                    idx_d      = '0;
                    err_d      = 1'b0;
                    state_next = CALC;
                end
            end

            CALC: begin
                diff_d[4*idx_q +: 4] = digit;
                borrow_d             = raw_neg;
                if (digit_bad) begin
                    err_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    bout_d      = raw_neg;
                    out_valid_d = 1'b1;
                    state_next  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end

            DONE: begin
                // Results stay put until the consumer takes them; re-accept
                // only happens from IDLE on a later cycle.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_next  = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            borrow_q  <= 1'b0;
            idx_q     <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            borrow_q  <= borrow_d;
            idx_q     <= idx_d;
            diff      <= diff_d;
            bout      <= bout_d;
            err       <= err_d;
            out_valid <= out_valid_d;
        end
    end

endmodule
